// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a synchronous, registered read port.
// DEPTH entries of WIDTH bits. It has full/empty flags and one-cycle
// overflow/underflow error pulses.
// Optional build macro FIFO_LEVEL_EN adds the level_o occupancy output.
//
// Handshake: a write is accepted on a rising edge when wr_en_i=1 and
// full_o=0. A read is accepted when rd_en_i=1 and empty_o=0. Accepted read
// data appears on rdata_o one cycle later and holds until the next accepted
// read. A request made while the flag blocks it is dropped, and the matching
// *_error_o flag is raised for exactly the following cycle.
module sync_fifo #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int PTR_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic                 full_o,
    output logic                 wr_error_o,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 empty_o,
    output logic                 rd_error_o
`ifdef FIFO_LEVEL_EN
    ,
    output logic [PTR_WIDTH:0]   level_o
`endif
);

    localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so that full and empty are distinguishable.
    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic               wr_accept;
    logic               rd_accept;

    // Flags come from the registered pointers, so each decision uses the state before the edge.
    assign empty_o   = (wr_ptr == rd_ptr);
    assign full_o    = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                       (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
    assign wr_accept = wr_en_i && !full_o;
    assign rd_accept = rd_en_i && !empty_o;

`ifdef FIFO_LEVEL_EN
    // Occupancy: the modulo difference of the wrap-extended pointers, range 0..DEPTH.
    assign level_o = wr_ptr - rd_ptr;
`endif

    // Storage write; the array is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem[wr_ptr[PTR_WIDTH-1:0]] <= wdata_i;
        end
    end

    // Write pointer advance and the one-cycle overflow pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr     <= '0;
            wr_error_o <= 1'b0;
        end else begin
            wr_error_o <= wr_en_i && full_o;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

    // Registered read data, read pointer advance and the one-cycle underflow pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr     <= '0;
            rdata_o    <= '0;
            rd_error_o <= 1'b0;
        end else begin
            rd_error_o <= rd_en_i && empty_o;
            if (rd_accept) begin
                rdata_o <= mem[rd_ptr[PTR_WIDTH-1:0]];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo (DEPTH 16, WIDTH 8).
// Builds with or without FIFO_LEVEL_EN.
module tb_sync_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int PW    = 4;

    // ---------------- clock / reset ----------------
    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             wr_en_i = 1'b0;
    logic [WIDTH-1:0] wdata_i = '0;
    logic             rd_en_i = 1'b0;
    logic             full_o;
    logic             wr_error_o;
    logic [WIDTH-1:0] rdata_o;
    logic             empty_o;
    logic             rd_error_o;
`ifdef FIFO_LEVEL_EN
    logic [PW:0]      level_o;
`endif

    always #5 clk_i = ~clk_i;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_WIDTH(PW)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wr_en_i    (wr_en_i),
        .wdata_i    (wdata_i),
        .full_o     (full_o),
        .wr_error_o (wr_error_o),
        .rd_en_i    (rd_en_i),
        .rdata_o    (rdata_o),
        .empty_o    (empty_o),
        .rd_error_o (rd_error_o)
`ifdef FIFO_LEVEL_EN
        ,
        .level_o    (level_o)
`endif
    );

    // ---------------- scoreboard / model state ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_rdata;
    logic             m_wr_err;
    logic             m_rd_err;
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rdata  = '0;
        m_wr_err = 1'b0;
        m_rd_err = 1'b0;
    endtask

    task automatic check_model();
        check("rdata", 32'(rdata_o), 32'(m_rdata));
        check("full", 32'(full_o), 32'(exp_q.size() == DEPTH));
        check("empty", 32'(empty_o), 32'(exp_q.size() == 0));
        check("wr_error", 32'(wr_error_o), 32'(m_wr_err));
        check("rd_error", 32'(rd_error_o), 32'(m_rd_err));
`ifdef FIFO_LEVEL_EN
        check("level", 32'(level_o), 32'(exp_q.size()));
`endif
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive on the falling edge, update the model, then sample
    // 1 ns after the rising edge.
    task automatic cycle(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
        bit pre_full;
        bit pre_empty;
        @(negedge clk_i);
        wr_en_i = wr;
        rd_en_i = rd;
        wdata_i = d;
        pre_full  = (exp_q.size() == DEPTH);
        pre_empty = (exp_q.size() == 0);
        m_wr_err  = wr && pre_full;
        m_rd_err  = rd && pre_empty;
        if (rd && !pre_empty) m_rdata = exp_q.pop_front();
        if (wr && !pre_full) exp_q.push_back(d);
        @(posedge clk_i);
        #1;
        check_model();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0);
    endtask

    // Assert reset in the middle of the high phase and check the outputs at once.
    task automatic mid_clock_reset();
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        #1;
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_rdata", 32'(rdata_o), 32'd0);
        check("rst_wr_error", 32'(wr_error_o), 32'd0);
        check("rst_rd_error", 32'(rd_error_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic             wr;
        logic             rd;
        logic [WIDTH-1:0] data;
        logic             e_full;
        logic             e_empty;
        logic             e_wr_err;
        logic             e_rd_err;
        logic [WIDTH-1:0] e_rdata;
    } vec_t;

    vec_t vecs[8];

    // Watchdog: the bench must never hang.
    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        rst_n_i = 1'b1;

        // Reset applied in the middle of a clock.
        mid_clock_reset();

        // The table starts from an empty FIFO whose rdata is 0.
        vecs[0] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00}; // read while empty
        vecs[1] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // write A5
        vecs[2] = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5}; // write 3C + read A5
        vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5}; // rdata holds
        vecs[4] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C}; // read 3C -> empty
        vecs[5] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C}; // both on empty
        vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77}; // read 77
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77}; // flags clear
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].wr, vecs[i].rd, vecs[i].data);
            check("vec_full", 32'(full_o), 32'(vecs[i].e_full));
            check("vec_empty", 32'(empty_o), 32'(vecs[i].e_empty));
            check("vec_wr_error", 32'(wr_error_o), 32'(vecs[i].e_wr_err));
            check("vec_rd_error", 32'(rd_error_o), 32'(vecs[i].e_rd_err));
            check("vec_rdata", 32'(rdata_o), 32'(vecs[i].e_rdata));
        end

        // Fill, overflow, drain and underflow.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, WIDTH'($urandom_range(0, 255)));
        check("fill_full", 32'(full_o), 32'd1);
        check("fill_empty", 32'(empty_o), 32'd0);
`ifdef FIFO_LEVEL_EN
        check("fill_level", 32'(level_o), 32'd16);
`endif
        cycle(1'b1, 1'b0, 8'hEE);                   // 17th write: dropped
        check("ovf_pulse", 32'(wr_error_o), 32'd1);
        idle();
        check("ovf_clear", 32'(wr_error_o), 32'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0);
        check("drain_empty", 32'(empty_o), 32'd1);
        cycle(1'b0, 1'b1, '0);                      // 17th read: underflow
        check("udf_pulse", 32'(rd_error_o), 32'd1);
        idle();
        check("udf_clear", 32'(rd_error_o), 32'd0);

        // Pointer wrap, then simultaneous access while full and while empty.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, WIDTH'($urandom_range(0, 255)));
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, '0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, WIDTH'($urandom_range(0, 255)));
        check("wrap_full", 32'(full_o), 32'd1);
        cycle(1'b1, 1'b1, 8'h5A);                   // read taken, write rejected
        check("full_both_wr_error", 32'(wr_error_o), 32'd1);
        check("full_both_not_full", 32'(full_o), 32'd0);
        while (exp_q.size() > 0) cycle(1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, 8'hC3);                   // write taken, read rejected
        check("empty_both_rd_error", 32'(rd_error_o), 32'd1);
        check("empty_both_not_empty", 32'(empty_o), 32'd0);
        cycle(1'b0, 1'b1, '0);
        check("empty_both_data", 32'(rdata_o), 32'hC3);

        // Concurrent traffic: 20 writes and 20 reads, each with a 1-5 cycle gap.
        begin
            int wr_left = 20;
            int rd_left = 20;
            int wr_gap  = $urandom_range(1, 5);
            int rd_gap  = $urandom_range(1, 5);
            int budget  = 0;
            while ((wr_left > 0 || rd_left > 0) && budget < 500) begin
                logic w;
                logic r;
                w = (wr_left > 0) && (wr_gap == 1);
                r = (rd_left > 0) && (rd_gap == 1);
                cycle(w, r, WIDTH'($urandom_range(0, 255)));
                if (w) begin wr_left--; wr_gap = $urandom_range(1, 5); end
                else if (wr_gap > 1) wr_gap--;
                if (r) begin rd_left--; rd_gap = $urandom_range(1, 5); end
                else if (rd_gap > 1) rd_gap--;
                budget++;
            end
            check("concurrent_done", 32'(budget < 500), 32'd1);
            budget = 0;
            while (exp_q.size() > 0 && budget < 40) begin
                cycle(1'b0, 1'b1, '0);
                budget++;
            end
            check("concurrent_drained", 32'(empty_o), 32'd1);
        end

        // Reset in mid-operation discards the contents.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, WIDTH'(8'h10 + i));
        mid_clock_reset();
        cycle(1'b0, 1'b1, '0);                      // nothing left: underflow
        check("post_rst_rd_error", 32'(rd_error_o), 32'd1);
        cycle(1'b1, 1'b0, 8'h99);
        cycle(1'b0, 1'b1, '0);
        check("post_rst_data", 32'(rdata_o), 32'h99);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, synchronous-read FIFO buffer: DEPTH entries of WIDTH bits, with full/empty flags and per-port overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain.
- Illegal accesses are rejected and flagged, never corrupt state.

Parameters:
- DEPTH, 16, number of storage entries; must equal 2**PTR_WIDTH.
- WIDTH, 8, data word width in bits.
- PTR_WIDTH, 4, address width; internal pointers are PTR_WIDTH+1 bits (extra wrap bit).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- wr_en_i  input  1  write request, sampled on clk_i rising edge.
- wdata_i  input  WIDTH  write data, sampled with wr_en_i.
- full_o  output  1  FIFO holds DEPTH entries.
- wr_error_o  output  1  previous cycle's write was attempted while full.
- rd_en_i  input  1  read request, sampled on clk_i rising edge.
- rdata_o  output  WIDTH  registered read data.
- empty_o  output  1  FIFO holds 0 entries.
- rd_error_o  output  1  previous cycle's read was attempted while empty.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - Write and read pointers = 0.
  - rdata_o = 0, wr_error_o = 0, rd_error_o = 0.
  - empty_o = 1, full_o = 0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents immediately.
- Pointers are PTR_WIDTH+1-bit binary. Low PTR_WIDTH bits address memory; the MSB toggles on each wrap.
- Flags are combinational from the registered pointers:
  - empty_o = pointers equal.
  - full_o = MSBs differ and low bits equal.
- Write, on a rising edge with wr_en_i=1:
  - Not full: mem[wr_ptr] <= wdata_i, wr_ptr increments (wraps DEPTH-1 -> 0 with MSB toggle), wr_error_o <= 0.
  - Full: no write, pointer unchanged, wr_error_o <= 1.
- Read, on a rising edge with rd_en_i=1:
  - Not empty: rdata_o <= mem[rd_ptr], rd_ptr increments, rd_error_o <= 0.
  - Empty: rdata_o holds its value, pointer unchanged, rd_error_o <= 1.
- Read latency: data is valid on rdata_o one cycle after the accepted rd_en_i edge. rdata_o holds between reads.
- Error flags reflect only the most recent edge. An edge with the enable low clears the corresponding flag, so each flag is a one-cycle pulse per illegal attempt.
- Full/empty decisions use the state before the edge.
- Simultaneous read and write:
  - Neither full nor empty: both are performed; occupancy is unchanged.
  - Full: the read is performed; the write is rejected with wr_error_o=1.
  - Empty: the write is performed; the read is rejected with rd_error_o=1 (no fall-through).
- FIFO order is strict: data is read in write order across any number of pointer wraps.

Optional Feature:
- Macro FIFO_LEVEL_EN.
- When defined: adds output level_o [PTR_WIDTH:0] = wr_ptr - rd_ptr (modulo 2**(PTR_WIDTH+1)), range 0..DEPTH. Reset value 0; updates combinationally from the pointers.
- When undefined: no level_o port and no extra logic; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n_i low mid-clock -> immediately empty_o=1, full_o=0, rdata_o=0, wr_error_o=0, rd_error_o=0.
- Fill: 16 consecutive writes of random data -> full_o=1 after the 16th edge and empty_o=0; level_o=16 if FIFO_LEVEL_EN.
- Overflow: 17 writes then 16 reads -> wr_error_o pulses 1 for exactly one cycle after the 17th write; the reads return the first 16 values in order; the 17th value is never output.
- Drain/underflow: 16 writes then 17 reads -> values returned in order; empty_o=1 after the 16th read; rd_error_o=1 after the 17th read; rdata_o keeps the 16th value.
- Concurrent: 20 writes and 20 reads, each with random 1-5 cycle gaps -> every value read matches a scoreboard in write order; errors occur only when empty/full at the request edge.
- Wrap and simultaneous access:
  - Write 10, read 10, write 16 (pointer wrap) -> full_o=1; all 16 read back in order.
  - With full, assert rd_en_i and wr_en_i together -> one read, write rejected, wr_error_o=1.
  - With empty, assert both together -> write accepted, rd_error_o=1, empty_o=0 next cycle.
